br_update_queue: RTL and testbench
==================================

Name: br_update_queue

Overview:
Buffers resolved-branch records from the execute (AGEX) stage and drains them, in order, to the branch predictor's update port over a valid/ready handshake. It also maintains the committed global history register (GHR), including restore on mispredict.

Parameters:
PC_BITS, 32, width of branch PC and target fields
GHR_BITS, 8, global history register width (>=2)
DEPTH, 4, queue entries; power of two, >=2
CNT_BITS, 16, width of saturating drop counter

Ports:
clk  input  1  clock; all state changes on rising edge
reset_n  input  1  asynchronous, active-low reset
res_valid  input  1  AGEX presents a resolved conditional branch this cycle
res_pc  input  PC_BITS  PC of resolved branch
res_taken  input  1  actual direction
res_target  input  PC_BITS  actual target
res_mispred  input  1  direction or target was mispredicted
res_ghr  input  GHR_BITS  GHR snapshot used when this branch was predicted
upd_valid  output  1  head entry available to predictor
upd_ready  input  1  predictor accepts head this cycle
upd_pc  output  PC_BITS  head entry PC
upd_taken  output  1  head entry direction
upd_target  output  PC_BITS  head entry target
upd_ghr  output  GHR_BITS  head entry res_ghr snapshot, used as predictor index
ghr  output  GHR_BITS  committed global history
occupancy  output  log2(DEPTH)+1  entries held
drop_cnt  output  CNT_BITS  resolutions lost to a full queue; saturating

Behaviour:
- Reset (async assert, sync-free deassert): rd_ptr = wr_ptr = 0, occupancy = 0, upd_valid = 0, ghr = 0, drop_cnt = 0. Entry storage is not cleared. Outputs upd_pc, upd_taken, upd_target, upd_ghr are don't-care while upd_valid = 0.
- Pointers: log2(DEPTH)+1 bits.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and the low bits are equal.
  - Wrap-around is natural overflow.
- Dequeue: occurs when upd_valid & upd_ready; rd_ptr increments.
  - upd_valid = !empty.
  - Head fields come directly from storage at rd_ptr (show-ahead), so there is no extra read latency.
  - upd_valid is never withdrawn without a handshake.
- Enqueue: occurs when res_valid & (!full | deq_fire).
  - Writes {res_pc, res_taken, res_target, res_ghr} at wr_ptr; wr_ptr increments.
  - Latency from res_valid to upd_valid on an empty queue is 1 cycle. There is no bypass of an empty queue.
- Full with simultaneous dequeue: the enqueue is accepted; occupancy stays at DEPTH.
- Empty with simultaneous res_valid: no dequeue that cycle; upd_valid rises the next cycle.
- Drop: res_valid & full & !deq_fire.
  - The record is discarded.
  - drop_cnt increments, saturating at 2^CNT_BITS-1.
  - GHR still updates.
- occupancy: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
- GHR update: on every res_valid, independent of drop, registered.
  - If res_mispred = 0: ghr <= {ghr[GHR_BITS-2:0], res_taken}.
  - If res_mispred = 1: ghr <= {res_ghr[GHR_BITS-2:0], res_taken}, i.e. restore from snapshot plus the actual outcome.
- Ordering: entries drain strictly in enqueue order. The block never reorders, merges, or duplicates entries.
- Reset mid-operation: all in-flight entries are lost. upd_valid drops to 0 asynchronously. The first post-reset enqueue is written to slot 0.
- No combinational path from upd_ready to upd_valid. deq_fire feeds only the enqueue acceptance logic.

Test Plan:
1. Reset then idle 5 cycles -> upd_valid = 0, occupancy = 0, ghr = 0x00, drop_cnt = 0.
2. Single resolution: res_valid = 1, pc = 0x100, taken = 1, target = 0x140, mispred = 0, res_ghr = 0x00, upd_ready = 0 -> next cycle upd_valid = 1, upd_pc = 0x100, upd_target = 0x140, ghr = 0x01, occupancy = 1. Raise upd_ready -> next cycle upd_valid = 0, occupancy = 0.
3. upd_ready held 0, 5 consecutive resolutions with pc = 0x10, 0x20, 0x30, 0x40, 0x50 -> occupancy = 4, drop_cnt = 1. Draining yields exactly 0x10, 0x20, 0x30, 0x40.
4. Queue full, upd_ready = 1 and res_valid (pc = 0x60) in the same cycle -> drop_cnt unchanged, occupancy stays 4, 0x60 is emitted last.
5. ghr = 0xAA, then resolution with mispred = 1, taken = 0, res_ghr = 0x0F -> ghr = 0x1E. Next non-mispredicted resolution with taken = 1 -> ghr = 0x3D.
6. Wrap and reset: stream 10 resolutions with upd_ready toggling every cycle -> all 10 emerge in order with no drops. Then assert reset_n = 0 with occupancy = 2 -> upd_valid = 0 immediately, and the first new entry appears from slot 0.

Source files
------------

// File: rtl/br_update_queue.sv
// Branch update queue: buffers resolved branches from AGEX and drains them in order
// to the predictor update port, while tracking the committed global history register.
module br_update_queue #(
  parameter int PC_BITS  = 32,
  parameter int GHR_BITS = 8,
  parameter int DEPTH    = 4,
  parameter int CNT_BITS = 16,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                res_valid,
  input  logic [PC_BITS-1:0]  res_pc,
  input  logic                res_taken,
  input  logic [PC_BITS-1:0]  res_target,
  input  logic                res_mispred,
  input  logic [GHR_BITS-1:0] res_ghr,
  output logic                upd_valid,
  input  logic                upd_ready,
  output logic [PC_BITS-1:0]  upd_pc,
  output logic                upd_taken,
  output logic [PC_BITS-1:0]  upd_target,
  output logic [GHR_BITS-1:0] upd_ghr,
  output logic [GHR_BITS-1:0] ghr,
  output logic [AW:0]         occupancy,
  output logic [CNT_BITS-1:0] drop_cnt
);

  // Handshake: a record transfers on any cycle where upd_valid && upd_ready; upd_valid
  // depends only on registered pointers and is held until that transfer happens.
  localparam logic [AW:0]         PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic [PC_BITS-1:0]  r_pc_mem     [DEPTH];
  logic                r_taken_mem  [DEPTH];
  logic [PC_BITS-1:0]  r_target_mem [DEPTH];
  logic [GHR_BITS-1:0] r_ghr_mem    [DEPTH];

  logic [AW:0]         r_wr_ptr;
  logic [AW:0]         r_rd_ptr;
  logic [GHR_BITS-1:0] r_ghr;
  logic [CNT_BITS-1:0] r_drop_cnt;

  logic w_empty;
  logic w_full;
  logic w_deq_fire;
  logic w_enq;
  logic w_drop;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_deq_fire = upd_valid && upd_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign w_enq      = res_valid && (!w_full || w_deq_fire);
  assign w_drop     = res_valid && w_full && !w_deq_fire;

  assign upd_valid  = !w_empty;
  assign upd_pc     = r_pc_mem[r_rd_ptr[AW-1:0]];
  assign upd_taken  = r_taken_mem[r_rd_ptr[AW-1:0]];
  assign upd_target = r_target_mem[r_rd_ptr[AW-1:0]];
  assign upd_ghr    = r_ghr_mem[r_rd_ptr[AW-1:0]];
  assign ghr        = r_ghr;
  assign occupancy  = r_wr_ptr - r_rd_ptr;
  assign drop_cnt   = r_drop_cnt;

  // Entry storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc_mem[r_wr_ptr[AW-1:0]]     <= res_pc;
      r_taken_mem[r_wr_ptr[AW-1:0]]  <= res_taken;
      r_target_mem[r_wr_ptr[AW-1:0]] <= res_target;
      r_ghr_mem[r_wr_ptr[AW-1:0]]    <= res_ghr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ghr      <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_enq)      r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_deq_fire) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      // History follows every resolution, even dropped ones; a mispredict
      // rebuilds it from the snapshot taken at prediction time.
      if (res_valid) begin
        if (res_mispred) r_ghr <= {res_ghr[GHR_BITS-2:0], res_taken};
        else             r_ghr <= {r_ghr[GHR_BITS-2:0], res_taken};
      end
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_br_update_queue.sv
// Directed bench for br_update_queue: reset, ordering, full/drop, GHR restore,
// pointer wrap and asynchronous reset mid-stream.
module tb_br_update_queue;

  logic        clk;
  logic        reset_n;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_mispred;
  logic [7:0]  res_ghr;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [7:0]  upd_ghr;
  logic [7:0]  ghr;
  logic [2:0]  occupancy;
  logic [15:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  br_update_queue #(
    .PC_BITS(32), .GHR_BITS(8), .DEPTH(4), .CNT_BITS(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .res_mispred(res_mispred), .res_ghr(res_ghr),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_ghr(upd_ghr),
    .ghr(ghr), .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one resolution for exactly one cycle.
  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic mp, input logic [7:0] sg);
    res_valid   = 1'b1;
    res_pc      = pc;
    res_taken   = tk;
    res_target  = tgt;
    res_mispred = mp;
    res_ghr     = sg;
    tick();
    res_valid   = 1'b0;
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] drain_pc [4];
  logic [7:0]  drain_ghr [3];
  logic        drain_tk [3];

  initial begin
    reset_n = 1'b0; res_valid = 1'b0; res_pc = '0; res_taken = 1'b0;
    res_target = '0; res_mispred = 1'b0; res_ghr = '0; upd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: reset then idle
    repeat (5) tick();
    chk("rst_valid", upd_valid, 0);
    chk("rst_occ",   occupancy, 0);
    chk("rst_ghr",   ghr, 8'h00);
    chk("rst_drop",  drop_cnt, 0);

    // 2: single resolution, one-cycle latency, then dequeue
    resolve(32'h100, 1'b1, 32'h140, 1'b0, 8'h00);
    chk("t2_valid",  upd_valid, 1);
    chk("t2_pc",     upd_pc, 32'h100);
    chk("t2_target", upd_target, 32'h140);
    chk("t2_taken",  upd_taken, 1);
    chk("t2_ghr",    ghr, 8'h01);
    chk("t2_occ",    occupancy, 1);
    upd_ready = 1'b1;
    tick();
    upd_ready = 1'b0;
    chk("t2_valid_after", upd_valid, 0);
    chk("t2_occ_after",   occupancy, 0);

    // 3: five resolutions into a 4-deep queue, last one dropped
    for (int i = 1; i <= 5; i++) resolve(32'h10 * i, 1'b0, 32'h1000 + i, 1'b0, 8'h00);
    chk("t3_occ",  occupancy, 4);
    chk("t3_drop", drop_cnt, 1);
    chk("t3_head", upd_pc, 32'h10);
    chk("t3_ghr",  ghr, 8'h20);

    // 4: full queue with simultaneous dequeue accepts the new record
    upd_ready = 1'b1;
    resolve(32'h60, 1'b0, 32'h1060, 1'b0, 8'h00);
    upd_ready = 1'b0;
    chk("t4_drop", drop_cnt, 1);
    chk("t4_occ",  occupancy, 4);
    chk("t4_ghr",  ghr, 8'h40);
    drain_pc[0] = 32'h20; drain_pc[1] = 32'h30; drain_pc[2] = 32'h40; drain_pc[3] = 32'h60;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain_valid", upd_valid, 1);
      chk("t4_drain_pc", upd_pc, drain_pc[i]);
      upd_ready = 1'b1;
      tick();
      upd_ready = 1'b0;
    end
    chk("t4_empty", upd_valid, 0);
    chk("t4_occ_end", occupancy, 0);

    // 5: GHR restore on mispredict, then normal shift
    resolve(32'h500, 1'b0, 32'h504, 1'b1, 8'h55);
    chk("t5_ghr_aa", ghr, 8'hAA);
    resolve(32'h510, 1'b0, 32'h514, 1'b1, 8'h0F);
    chk("t5_ghr_restore", ghr, 8'h1E);
    resolve(32'h520, 1'b1, 32'h600, 1'b0, 8'h00);
    chk("t5_ghr_shift", ghr, 8'h3D);
    chk("t5_occ", occupancy, 3);
    drain_ghr[0] = 8'h55; drain_ghr[1] = 8'h0F; drain_ghr[2] = 8'h00;
    drain_tk[0]  = 1'b0;  drain_tk[1]  = 1'b0;  drain_tk[2]  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_upd_ghr", upd_ghr, drain_ghr[i]);
      chk("t5_upd_taken", upd_taken, drain_tk[i]);
      upd_ready = 1'b1;
      tick();
      upd_ready = 1'b0;
    end
    chk("t5_empty", upd_valid, 0);

    // 6: stream 10 records through with upd_ready toggling; pointers wrap
    begin
      int sent = 0;
      int cyc  = 0;
      while ((sent < 10 || exp_q.size() > 0) && cyc < 60) begin
        upd_ready = ((cyc % 2) == 1);
        res_valid = (sent < 10) && ((cyc % 3) != 2);
        res_mispred = 1'b0;
        res_taken = 1'b0;
        if (upd_ready) begin
          if (exp_q.size() > 0) begin
            chk("t6_valid", upd_valid, 1);
            chk("t6_pc", upd_pc, exp_q.pop_front());
          end else begin
            chk("t6_idle", upd_valid, 0);
          end
        end
        if (res_valid) begin
          res_pc = 32'h200 + 32'(sent * 4);
          exp_q.push_back(res_pc);
          sent++;
        end
        tick();
        cyc++;
      end
      res_valid = 1'b0;
      upd_ready = 1'b0;
      chk("t6_in_time", (cyc < 60), 1);
      chk("t6_no_drop", drop_cnt, 1);
      chk("t6_empty", upd_valid, 0);
    end

    // 6b: asynchronous reset with two entries held
    resolve(32'h300, 1'b1, 32'h340, 1'b0, 8'h00);
    resolve(32'h304, 1'b1, 32'h344, 1'b0, 8'h00);
    chk("t6_occ2", occupancy, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", upd_valid, 0);
    chk("t6_rst_occ", occupancy, 0);
    chk("t6_rst_ghr", ghr, 8'h00);
    chk("t6_rst_drop", drop_cnt, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    resolve(32'h400, 1'b1, 32'h440, 1'b0, 8'h00);
    chk("t6_post_valid", upd_valid, 1);
    chk("t6_post_pc", upd_pc, 32'h400);
    chk("t6_post_slot", dut.r_wr_ptr, 1);
    chk("t6_post_occ", occupancy, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
